rf68000_addsub_seq: RTL and testbench

Multi-precision add/subtract sequencer for the 8-bit add/sub slice.
- Runs byte, word and long ADD/SUB/ADDX/SUBX through one shared 8-bit slice, one byte per clock, least significant byte first, chaining carry/borrow between bytes.
- Produces the 68000-style C, V, Z, N and X flags.
- Sits between the instruction sequencer and the narrow ALU path. It trades latency for area when the full-width adder is not used.

---
 rtl/rf68000_addsub_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_rf68000_addsub_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf68000_addsub_seq.sv
// rf68000_addsub_seq
// Multi-precision ADD/SUB/ADDX/SUBX sequencer built around one 8-bit
// add/subtract slice. Operands are latched at start and processed one byte
// per clock, least significant byte first, with the carry (or borrow)
// chained between bytes. 68000-style C, V, Z, N and X flags are produced
// together with the result on the single clock that enters DONE.

module rf68000_addsub_seq (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        op_i,
   input  logic [1:0]  size_i,
   input  logic        ext_i,
   input  logic        x_i,
   input  logic        z_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] res_o,
   output logic        c_o,
   output logic        v_o,
   output logic        z_o,
   output logic        n_o,
   output logic        x_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;

   // Latched operation context
   logic        op_q,    op_d;
   logic [1:0]  last_q,  last_d;
   logic [31:0] a_q,     a_d;
   logic [31:0] b_q,     b_d;

   // Byte sequencing and running accumulators
   logic [1:0]  k_q,     k_d;
   logic        carry_q, carry_d;
   logic [31:0] acc_q,   acc_d;
   logic        zacc_q,  zacc_d;

   // Visible result and flags
   logic [31:0] res_q,   res_d;
   logic        c_q,     c_d;
   logic        v_q,     v_d;
   logic        z_q,     z_d;
   logic        n_q,     n_d;

   // Slice inputs and outputs
   logic [7:0]  a_byte;
   logic [7:0]  b_byte;
   logic [8:0]  sum_add;
   logic [8:0]  sum_sub;
   logic [8:0]  sum9;
   logic [7:0]  slice_r;
   logic        slice_cout;
   logic        slice_v;
   logic        slice_zero;
   logic [31:0] acc_new;
   logic        last_byte;

   // Pick the operand byte pair addressed by the current byte index
   always_comb begin
      a_byte = 8'h00;
      b_byte = 8'h00;
      case (k_q)
         2'd0: begin
            a_byte = a_q[7:0];
            b_byte = b_q[7:0];
         end
         2'd1: begin
            a_byte = a_q[15:8];
            b_byte = b_q[15:8];
         end
         2'd2: begin
            a_byte = a_q[23:16];
            b_byte = b_q[23:16];
         end
         default: begin
            a_byte = a_q[31:24];
            b_byte = b_q[31:24];
         end
      endcase
   end

   // The shared 8-bit slice: 9-bit add or subtract, bit 8 is carry or borrow.
   // For subtraction a 9-bit wrap leaves bit 8 set exactly when a-b-bin < 0.
   always_comb begin
      sum_add    = {1'b0, a_byte} + {1'b0, b_byte} + {8'h00, carry_q};
      sum_sub    = {1'b0, a_byte} - {1'b0, b_byte} - {8'h00, carry_q};
      sum9       = op_q ? sum_sub : sum_add;
      slice_r    = sum9[7:0];
      slice_cout = sum9[8];
      slice_zero = (slice_r == 8'h00);
      if (op_q) begin
         slice_v = (a_byte[7] ^ b_byte[7]) & (a_byte[7] ^ slice_r[7]);
      end else begin
         slice_v = ~(a_byte[7] ^ b_byte[7]) & (a_byte[7] ^ slice_r[7]);
      end
   end

   // Merge the slice result into the accumulator, which starts as a copy of
   // the destination so bytes above the operand size are preserved
   always_comb begin
      acc_new = acc_q;
      case (k_q)
         2'd0:    acc_new[7:0]   = slice_r;
         2'd1:    acc_new[15:8]  = slice_r;
         2'd2:    acc_new[23:16] = slice_r;
         default: acc_new[31:24] = slice_r;
      endcase
      last_byte = (k_q == last_q);
   end

   // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      last_d  = last_q;
      a_d     = a_q;
      b_d     = b_q;
      k_d     = k_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      zacc_d  = zacc_q;
      res_d   = res_q;
      c_d     = c_q;
      v_d     = v_q;
      z_d     = z_q;
      n_d     = n_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               op_d    = op_i;
               a_d     = a_i;
               b_d     = b_i;
               acc_d   = a_i;
               k_d     = 2'd0;
               carry_d = ext_i & x_i;
               // Sticky Z for the extended forms simply starts from z_i
               zacc_d  = ext_i ? z_i : 1'b1;
               case (size_i)
                  2'b00:   last_d = 2'd0;
                  2'b01:   last_d = 2'd1;
                  default: last_d = 2'd3;
               endcase
               state_d = RUN;
            end
         end

         RUN: begin
            acc_d   = acc_new;
            carry_d = slice_cout;
            zacc_d  = zacc_q & slice_zero;
            k_d     = k_q + 2'd1;
            if (last_byte) begin
               res_d   = acc_new;
               c_d     = slice_cout;
               v_d     = slice_v;
               n_d     = slice_r[7];
               z_d     = zacc_q & slice_zero;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         op_q    <= 1'b0;
         last_q  <= 2'd0;
         a_q     <= 32'h0;
         b_q     <= 32'h0;
         k_q     <= 2'd0;
         carry_q <= 1'b0;
         acc_q   <= 32'h0;
         zacc_q  <= 1'b0;
         res_q   <= 32'h0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         last_q  <= last_d;
         a_q     <= a_d;
         b_q     <= b_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         zacc_q  <= zacc_d;
         res_q   <= res_d;
         c_q     <= c_d;
         v_q     <= v_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = (state_q == DONE);
   assign res_o  = res_q;
   assign c_o    = c_q;
   assign v_o    = v_q;
   assign z_o    = z_q;
   assign n_o    = n_q;
   assign x_o    = c_q;

endmodule

// File: tb/tb_rf68000_addsub_seq.sv
// Testbench for rf68000_addsub_seq: directed scenarios plus randomized
// operations checked against a whole-width arithmetic reference model.

module tb_rf68000_addsub_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic        op;
   logic [1:0]  size;
   logic        ext;
   logic        xin;
   logic        zin;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] res;
   logic        c_f, v_f, z_f, n_f, x_f;

   int n_vec = 0;
   int n_err = 0;

   rf68000_addsub_seq dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .op_i    (op),
      .size_i  (size),
      .ext_i   (ext),
      .x_i     (xin),
      .z_i     (zin),
      .a_i     (a),
      .b_i     (b),
      .busy_o  (busy),
      .done_o  (done),
      .res_o   (res),
      .c_o     (c_f),
      .v_o     (v_f),
      .z_o     (z_f),
      .n_o     (n_f),
      .x_o     (x_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {res, C, V, Z, N, X} from whole-width integer arithmetic
   function automatic logic [36:0] model(input bit mop, input bit [1:0] msize,
                                         input bit mext, input bit mx, input bit mz,
                                         input bit [31:0] ma, input bit [31:0] mb);
      longint w, mask, ua, ub, cin, sa, sb, sr, ur, hi, lo;
      bit c, v, n, zf;
      bit [31:0] r;
      w    = (msize == 2'd0) ? 8 : (msize == 2'd1) ? 16 : 32;
      mask = (longint'(1) << w) - 1;
      ua   = longint'(ma) & mask;
      ub   = longint'(mb) & mask;
      cin  = (mext && mx) ? 1 : 0;
      sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (mask + 1) : ua;
      sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (mask + 1) : ub;
      hi   = (longint'(1) << (w - 1)) - 1;
      lo   = -(longint'(1) << (w - 1));
      if (!mop) begin
         ur = ua + ub + cin;
         c  = (ur > mask);
         sr = sa + sb + cin;
      end else begin
         ur = ua - ub - cin;
         c  = ((ub + cin) > ua);
         sr = sa - sb - cin;
      end
      v  = (sr > hi) || (sr < lo);
      ur = ur & mask;
      r  = (ma & ~32'(mask)) | 32'(ur);
      n  = ((ur >> (w - 1)) & 1) != 0;
      zf = (ur == 0) && (!mext || mz);
      return {r, c, v, zf, n, c};
   endfunction

   function automatic int nbytes(input bit [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   // Launch one operation and wait (bounded) for done; lat = -1 on timeout
   task automatic run_op(input bit rop, input bit [1:0] rsize, input bit rext,
                         input bit rx, input bit rz, input bit [31:0] ra,
                         input bit [31:0] rb, output int lat);
      @(negedge clk);
      op = rop; size = rsize; ext = rext; xin = rx; zin = rz; a = ra; b = rb;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = e;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 1'b0; size = 2'd0; ext = 1'b0;
      xin = 1'b0; zin = 1'b0; a = 32'h0; b = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({busy, done, res, c_f, v_f, z_f, n_f, x_f} !== 39'h0) begin
         n_err++;
         $display("[TB] FAIL reset_state: got %h expected 0",
                  {busy, done, res, c_f, v_f, z_f, n_f, x_f});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_byte_add();
      int lat;
      run_op(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h1234567F, 32'h00000001, lat);
      n_vec++;
      if (lat !== 1) begin
         n_err++; $display("[TB] FAIL byte_add_latency: got %0d expected 1", lat);
      end
      n_vec++;
      if ({res, c_f, v_f, z_f, n_f, x_f} !== {32'h12345680, 5'b01010}) begin
         n_err++;
         $display("[TB] FAIL byte_add_result: got %h expected %h",
                  {res, c_f, v_f, z_f, n_f, x_f}, {32'h12345680, 5'b01010});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_long_sub();
      int lat;
      run_op(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000001, lat);
      n_vec++;
      if (lat !== 4) begin
         n_err++; $display("[TB] FAIL long_sub_latency: got %0d expected 4", lat);
      end
      n_vec++;
      if ({res, c_f, v_f, z_f, n_f, x_f} !== {32'hFFFFFFFF, 5'b10011}) begin
         n_err++;
         $display("[TB] FAIL long_sub_result: got %h expected %h",
                  {res, c_f, v_f, z_f, n_f, x_f}, {32'hFFFFFFFF, 5'b10011});
      end
      @(posedge clk); #1;
      n_vec++;
      if ({busy, done} !== 2'b00) begin
         n_err++; $display("[TB] FAIL long_sub_busy_fall: got %b expected 00", {busy, done});
      end
   endtask

   task automatic test_word_addx();
      int lat;
      bit [36:0] exp_v [3];
      bit [31:0] bv [3];
      bit        zv [3];
      exp_v[0] = {32'hAAAA0000, 5'b10101}; bv[0] = 32'h0000; zv[0] = 1'b1;
      exp_v[1] = {32'hAAAA0000, 5'b10001}; bv[1] = 32'h0000; zv[1] = 1'b0;
      exp_v[2] = {32'hAAAA0001, 5'b10001}; bv[2] = 32'h0001; zv[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b0, 2'd1, 1'b1, 1'b1, zv[i], 32'hAAAAFFFF, bv[i], lat);
         n_vec++;
         if (lat !== 2) begin
            n_err++; $display("[TB] FAIL word_addx_latency[%0d]: got %0d expected 2", i, lat);
         end
         n_vec++;
         if ({res, c_f, v_f, z_f, n_f, x_f} !== exp_v[i]) begin
            n_err++;
            $display("[TB] FAIL word_addx_result[%0d]: got %h expected %h",
                     i, {res, c_f, v_f, z_f, n_f, x_f}, exp_v[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_long_overflow_ignored();
      int pulses = 0;
      int first  = -1;
      logic [36:0] got = '0;
      @(negedge clk);
      op = 1'b0; size = 2'd2; ext = 1'b0; xin = 1'b0; zin = 1'b0;
      a = 32'h7FFFFFFF; b = 32'h00000001; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            a = $urandom; b = $urandom; op = 1'b1; start = 1'b1;
         end else if (e == 2) begin
            a = ~a; size = 2'd0; start = 1'b0;
         end
         if (done) begin
            pulses++;
            if (first < 0) begin
               first = e;
               got   = {res, c_f, v_f, z_f, n_f, x_f};
            end
         end
      end
      n_vec++;
      if (first !== 4) begin
         n_err++; $display("[TB] FAIL ovf_latency: got %0d expected 4", first);
      end
      n_vec++;
      if (pulses !== 1) begin
         n_err++; $display("[TB] FAIL ovf_done_pulses: got %0d expected 1", pulses);
      end
      n_vec++;
      if (got !== {32'h80000000, 5'b01010}) begin
         n_err++;
         $display("[TB] FAIL ovf_result: got %h expected %h", got, {32'h80000000, 5'b01010});
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      @(negedge clk);
      op = 1'b0; size = 2'd2; ext = 1'b0; a = 32'h01020304; b = 32'h10203040;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({busy, done, res, c_f, v_f, z_f, n_f, x_f} !== 39'h0) begin
         n_err++;
         $display("[TB] FAIL reset_mid_run: got %h expected 0",
                  {busy, done, res, c_f, v_f, z_f, n_f, x_f});
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h11223305, 32'h00000007, lat);
      n_vec++;
      if (lat !== 1) begin
         n_err++; $display("[TB] FAIL post_reset_latency: got %0d expected 1", lat);
      end
      n_vec++;
      if ({res, c_f, v_f, z_f, n_f, x_f} !== {32'h112233FE, 5'b10011}) begin
         n_err++;
         $display("[TB] FAIL post_reset_sub: got %h expected %h",
                  {res, c_f, v_f, z_f, n_f, x_f}, {32'h112233FE, 5'b10011});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int lat;
      bit rop, rext, rx, rz;
      bit [1:0] rsize;
      bit [31:0] ra, rb;
      logic [36:0] expv, held;
      for (int i = 0; i < 40; i++) begin
         rop = $urandom; rsize = $urandom; rext = $urandom; rx = $urandom; rz = $urandom;
         ra = $urandom; rb = $urandom;
         if (i % 5 == 0) rb = ra & 32'h000000FF;
         if (i % 7 == 0) rb = (ra ^ 32'h80000000);
         expv = model(rop, rsize, rext, rx, rz, ra, rb);
         run_op(rop, rsize, rext, rx, rz, ra, rb, lat);
         n_vec++;
         if (lat !== nbytes(rsize)) begin
            n_err++;
            $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, nbytes(rsize));
         end
         n_vec++;
         if ({res, c_f, v_f, z_f, n_f, x_f} !== expv) begin
            n_err++;
            $display("[TB] FAIL rand_result[%0d] op=%0d size=%0d ext=%0d a=%h b=%h: got %h expected %h",
                     i, rop, rsize, rext, ra, rb, {res, c_f, v_f, z_f, n_f, x_f}, expv);
         end
         held = expv;
         @(posedge clk); #1;
         n_vec++;
         if ({busy, done, res, c_f, v_f, z_f, n_f, x_f} !== {2'b00, held}) begin
            n_err++;
            $display("[TB] FAIL rand_hold[%0d]: got %h expected %h",
                     i, {busy, done, res, c_f, v_f, z_f, n_f, x_f}, {2'b00, held});
         end
      end
   endtask

   task automatic test_back_to_back();
      bit [1:0]  sq [8];
      bit        oq [8];
      bit        eq [8];
      bit        xq [8];
      bit        zq [8];
      bit [31:0] aq [8];
      bit [31:0] bq [8];
      int nb;
      bit bad_done;
      for (int i = 0; i < 8; i++) begin
         sq[i] = $urandom; oq[i] = $urandom; eq[i] = $urandom;
         xq[i] = $urandom; zq[i] = $urandom; aq[i] = $urandom; bq[i] = $urandom;
      end
      @(negedge clk);
      op = oq[0]; size = sq[0]; ext = eq[0]; xin = xq[0]; zin = zq[0];
      a = aq[0]; b = bq[0]; start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (i < 7) begin
            op = oq[i+1]; size = sq[i+1]; ext = eq[i+1]; xin = xq[i+1]; zin = zq[i+1];
            a = aq[i+1]; b = bq[i+1];
         end else begin
            start = 1'b0;
         end
         nb = nbytes(sq[i]);
         bad_done = 1'b0;
         for (int e = 1; e <= nb; e++) begin
            @(posedge clk); #1;
            if (e < nb && done) bad_done = 1'b1;
         end
         n_vec++;
         if (bad_done || done !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL b2b_done_timing[%0d]: got early=%0d at_N=%b expected early=0 at_N=1",
                     i, bad_done, done);
         end
         n_vec++;
         if ({res, c_f, v_f, z_f, n_f, x_f} !== model(oq[i], sq[i], eq[i], xq[i], zq[i], aq[i], bq[i])) begin
            n_err++;
            $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", i,
                     {res, c_f, v_f, z_f, n_f, x_f},
                     model(oq[i], sq[i], eq[i], xq[i], zq[i], aq[i], bq[i]));
         end
         @(posedge clk); #1;
         n_vec++;
         if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL b2b_gap[%0d]: got busy/done %b expected 00", i, {busy, done});
         end
      end
   endtask

   initial begin
      test_reset();
      test_byte_add();
      test_long_sub();
      test_word_addx();
      test_long_overflow_ignored();
      test_reset_mid_run();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
